alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width.
REQ-002 Parameter OPW, default 4, ALU mode-code width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester operation request (bit i = requester i).
REQ-006 req_ready  output  2  per-requester accept; bit i high for exactly the accept cycle.
REQ-007 req0_op / req1_op  input  OPW  requested ALU mode code.
REQ-008 req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands.
REQ-009 rsp_valid  output  2  result valid toward granted requester only.
REQ-010 rsp_ready  input  2  per-requester result consume.
REQ-011 rsp_x  output  WIDTH  registered ALU result, shared by both requesters.
REQ-012 rsp_zero  output  1  registered ALU zero flag.
REQ-013 alu_a, alu_b  output  WIDTH  operands driven to the shared ALU.
REQ-014 alu_mode  output  OPW  mode driven to the shared ALU.
REQ-015 alu_x  input  WIDTH; alu_zero  input  1  combinational ALU result and flag.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states IDLE, EXEC, RESP; IDLE->EXEC on accept, EXEC->RESP unconditionally, RESP->IDLE when rsp_ready[g] high, else hold RESP.
REQ-018 In IDLE with any req_valid high, grant g is chosen, req_ready[g]=1 combinationally that cycle, op/a/b of g latched into operand registers.
REQ-019 req_ready SHALL be 0 in EXEC and RESP and for the non-granted requester.
REQ-020 In EXEC, alu_a/alu_b/alu_mode SHALL equal the latched operands; alu_x and alu_zero are captured into rsp_x/rsp_zero at the end of EXEC.
REQ-021 In IDLE and RESP, alu_a, alu_b, alu_mode SHALL be driven 0.
REQ-022 Latency: accept at cycle T -> rsp_valid[g] high at T+2; minimum issue interval 3 cycles.
REQ-023 rsp_x, rsp_zero, rsp_valid SHALL stay stable in RESP until rsp_ready[g]; rsp_ready of the non-granted bit is ignored.
REQ-024 A requester dropping req_valid while not accepted SHALL lose nothing; operands are sampled only on the accept cycle.
REQ-025 Opcodes are passed through unchanged; no opcode checking in this block.

Reset
REQ-026 On rst_n low (any state, including mid-EXEC/RESP): state IDLE, req_ready 0, rsp_valid 0, rsp_x 0, rsp_zero 0, busy 0, operand registers 0, last-grant pointer 1; in-flight operation discarded.
REQ-027 First accept after reset with both requesting SHALL go to requester 0.

Configuration
REQ-028 Macro ALU_ARB_ROUND_ROBIN_EN defined: when both req_valid high, grant the requester not granted last; pointer updates on every accept.
REQ-029 Macro undefined: fixed priority, requester 0 always wins; pointer logic absent; single-requester behaviour identical in both builds.

Structure
REQ-030 Shared package holds the FSM state enum (IDLE, EXEC, RESP), WIDTH/OPW defaults and the ALU mode-code constants (ADD=0000, SUB=0001, ... SGE=1101).
REQ-031 One sub-module, arb_rr2: 2-way grant selector (valid[1:0], pointer -> one-hot grant), containing the macro-dependent logic.

Verification
REQ-032 Reset, req0 ADD a=5 b=7, rsp_ready=1 -> req_ready[0] at T, rsp_valid[0] at T+2, rsp_x=12, rsp_zero=0, busy T+1..T+2.
REQ-033 req1 SUB a=9 b=9 with rsp_ready=0 for 4 cycles -> rsp_valid[1] held, rsp_x=0, rsp_zero=1 stable, req_ready stays 0, then IDLE after rsp_ready[1].
REQ-034 Both valid continuously, round-robin build -> grants 0,1,0,1; fixed-priority build -> grants 0,0,0,0.
REQ-035 rst_n low during EXEC of req0 -> rsp_valid never asserts, all outputs 0 asynchronously, next accept grants requester 0.
REQ-036 rsp_ready[0] pulsed while serving requester 1 -> no state change; alu_* outputs 0 outside EXEC.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_arbiter_pkg : shared types and constants for alu_arbiter     |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package alu_arbiter_pkg;

  localparam int ARB_WIDTH = 32;
  localparam int ARB_OPW   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_SEQ  = 4'b1011;
  localparam logic [3:0] ALU_SNE  = 4'b1100;
  localparam logic [3:0] ALU_SGE  = 4'b1101;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_arbiter_if : requester and shared-ALU bus for alu_arbiter    |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = ARB_WIDTH,
  parameter int OPW   = ARB_OPW
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [OPW-1:0]   req0_op;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_x;
  logic             rsp_zero;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_mode;
  logic [WIDTH-1:0] alu_x;
  logic             alu_zero;

  // Arbiter side
  modport slave (
    input  req_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
    input  rsp_ready, alu_x, alu_zero,
    output req_ready, rsp_valid, rsp_x, rsp_zero, alu_a, alu_b, alu_mode
  );

  // Requesters plus the ALU itself
  modport master (
    output req_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
    output rsp_ready, alu_x, alu_zero,
    input  req_ready, rsp_valid, rsp_x, rsp_zero, alu_a, alu_b, alu_mode
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter_arb_rr2.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | arb_rr2 : 2-way one-hot grant selector                           |
// | ALU_ARB_ROUND_ROBIN_EN: alternate on contention, else req0 wins  |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module arb_rr2 (
  input  logic [1:0] valid,
`ifdef ALU_ARB_ROUND_ROBIN_EN
  input  logic       last_gnt,
`endif
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    // On contention favour whoever was not served last
    if (valid == 2'b11) begin
      grant = last_gnt ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
`else
    if (valid[0]) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_arbiter : shares one combinational ALU between 2 requesters  |
// | Option macro: ALU_ARB_ROUND_ROBIN_EN          Rev 1.0            |
// +-----------------------------------------------------------------+
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = ARB_WIDTH,
  parameter int OPW   = ARB_OPW
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic          busy
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] EXEC = ST_EXEC;
  localparam logic [1:0] RESP = ST_RESP;

  logic [1:0]       state_q, state_d;
  logic             gnt_q, gnt_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             zero_q, zero_d;
  logic [1:0]       grant;
  logic             in_exec;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic             last_q, last_d;
`endif

  arb_rr2 u_arb (
    .valid    (bus.req_valid),
`ifdef ALU_ARB_ROUND_ROBIN_EN
    .last_gnt (last_q),
`endif
    .grant    (grant)
  );

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    x_d           = x_q;
    zero_d        = zero_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    last_d        = last_q;
`endif
    bus.req_ready = 2'b00;
    case (state_q)
      IDLE: begin
        // rst_n gating keeps req_ready low while reset is held
        if (rst_n && (bus.req_valid != 2'b00)) begin
          bus.req_ready = grant;
          gnt_d         = grant[1];
          op_d          = grant[1] ? bus.req1_op : bus.req0_op;
          a_d           = grant[1] ? bus.req1_a  : bus.req0_a;
          b_d           = grant[1] ? bus.req1_b  : bus.req0_b;
`ifdef ALU_ARB_ROUND_ROBIN_EN
          last_d        = grant[1];
`endif
          state_d       = EXEC;
        end
      end
      EXEC: begin
        x_d     = bus.alu_x;
        zero_d  = bus.alu_zero;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready[gnt_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      zero_q  <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      zero_q  <= zero_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign in_exec       = (state_q == EXEC);
  assign busy          = (state_q != IDLE);
  assign bus.rsp_valid = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_x     = x_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.alu_a     = in_exec ? a_q  : '0;
  assign bus.alu_b     = in_exec ? b_q  : '0;
  assign bus.alu_mode  = in_exec ? op_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_alu_arbiter : directed self-checking bench for alu_arbiter    |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(32), .OPW(4)) bus ();

  alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  // Stand-in ALU
  always_comb begin
    case (bus.alu_mode)
      ALU_ADD: bus.alu_x = bus.alu_a + bus.alu_b;
      ALU_SUB: bus.alu_x = bus.alu_a - bus.alu_b;
      default: bus.alu_x = bus.alu_a ^ bus.alu_b;
    endcase
    bus.alu_zero = (bus.alu_x == 32'd0);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic [3:0] exp_seq = 4'b1010;
`else
  logic [3:0] exp_seq = 4'b0000;
`endif

  initial begin
    logic g;
    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    bus.req0_op   = 4'd0;
    bus.req1_op   = 4'd0;
    bus.req0_a    = 32'd0;
    bus.req0_b    = 32'd0;
    bus.req1_a    = 32'd0;
    bus.req1_b    = 32'd0;
    repeat (3) @(negedge clk);
    check_val("rst_busy",      64'(busy),          64'd0);
    check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_val("rst_rsp_x",     64'(bus.rsp_x),     64'd0);
    check_val("rst_rsp_zero",  64'(bus.rsp_zero),  64'd0);
    check_val("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_val("rst_alu_a",     64'(bus.alu_a),     64'd0);
    bus.req_valid = 2'b00;
    rst_n         = 1'b1;
    @(negedge clk);

    // req0 ADD 5+7
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b01;
    bus.req0_op   = ALU_ADD;
    bus.req0_a    = 32'd5;
    bus.req0_b    = 32'd7;
    #1 check_val("add_req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    bus.req0_a    = 32'd99;
    check_val("add_busy_t1",   64'(busy),          64'd1);
    check_val("add_vld_t1",    64'(bus.rsp_valid), 64'd0);
    check_val("add_alu_a",     64'(bus.alu_a),     64'd5);
    check_val("add_alu_b",     64'(bus.alu_b),     64'd7);
    check_val("add_alu_mode",  64'(bus.alu_mode),  64'(ALU_ADD));
    check_val("add_rdy_exec",  64'(bus.req_ready), 64'd0);
    @(negedge clk);
    check_val("add_vld_t2",    64'(bus.rsp_valid), 64'd1);
    check_val("add_rsp_x",     64'(bus.rsp_x),     64'd12);
    check_val("add_rsp_zero",  64'(bus.rsp_zero),  64'd0);
    check_val("add_busy_t2",   64'(busy),          64'd1);
    check_val("add_alu_a_rsp", 64'(bus.alu_a),     64'd0);
    @(negedge clk);
    check_val("add_busy_t3",   64'(busy),          64'd0);
    check_val("add_vld_t3",    64'(bus.rsp_valid), 64'd0);

    // req1 SUB 9-9 with held response, stray rsp_ready[0] pulse
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b10;
    bus.req1_op   = ALU_SUB;
    bus.req1_a    = 32'd9;
    bus.req1_b    = 32'd9;
    #1 check_val("sub_req_ready", 64'(bus.req_ready), 64'd2);
    @(negedge clk);
    bus.req_valid = 2'b00;
    check_val("sub_alu_mode", 64'(bus.alu_mode), 64'(ALU_SUB));
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_val("sub_hold_vld",  64'(bus.rsp_valid), 64'd2);
      check_val("sub_hold_x",    64'(bus.rsp_x),     64'd0);
      check_val("sub_hold_zero", 64'(bus.rsp_zero),  64'd1);
      check_val("sub_hold_busy", 64'(busy),          64'd1);
      check_val("sub_hold_alu",  64'(bus.alu_b),     64'd0);
      bus.rsp_ready = (i == 1) ? 2'b01 : 2'b00;
      bus.req_valid = (i < 3)  ? 2'b01 : 2'b00;
      #1 check_val("sub_hold_rdy", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    check_val("sub_still_vld", 64'(bus.rsp_valid), 64'd2);
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    check_val("sub_done_busy", 64'(busy),          64'd0);
    check_val("sub_done_vld",  64'(bus.rsp_valid), 64'd0);

    // Contention: req0 ADD 1+1=2, req1 SUB 10-3=7
    bus.rsp_ready = 2'b11;
    bus.req0_op   = ALU_ADD;
    bus.req0_a    = 32'd1;
    bus.req0_b    = 32'd1;
    bus.req1_op   = ALU_SUB;
    bus.req1_a    = 32'd10;
    bus.req1_b    = 32'd3;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      g = exp_seq[k];
      #1 check_val("both_grant", 64'(bus.req_ready), g ? 64'd2 : 64'd1);
      @(negedge clk);
      @(negedge clk);
      check_val("both_vld", 64'(bus.rsp_valid), g ? 64'd2 : 64'd1);
      check_val("both_x",   64'(bus.rsp_x),     g ? 64'd7 : 64'd2);
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    @(negedge clk);

    // Reset in EXEC of req0 ADD 4+4
    bus.req0_a    = 32'd4;
    bus.req0_b    = 32'd4;
    bus.req_valid = 2'b01;
    #1 check_val("rx_req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    check_val("rx_busy_exec", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rx_busy",   64'(busy),          64'd0);
    check_val("rx_vld",    64'(bus.rsp_valid), 64'd0);
    check_val("rx_x",      64'(bus.rsp_x),     64'd0);
    check_val("rx_alu_a",  64'(bus.alu_a),     64'd0);
    check_val("rx_alu_md", 64'(bus.alu_mode),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_val("rx_no_vld", 64'(bus.rsp_valid), 64'd0);
    end
    bus.req_valid = 2'b11;
    #1 check_val("rx_first_grant", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    check_val("rx_vld_after", 64'(bus.rsp_valid), 64'd1);
    check_val("rx_x_after",   64'(bus.rsp_x),     64'd8);
    @(negedge clk);
    check_val("rx_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
